// File: rtl/dcache_pkg.sv
// Shared types and geometry for the direct-mapped write-back data cache.
// Default geometry: 8-bit address, 8 lines of 4 bytes (tag[7:5], index[4:2], offset[1:0]).
package dcache_pkg;

   localparam int DC_N           = 8;
   localparam int DC_LINES       = 8;
   localparam int DC_BLOCK_BYTES = 4;
   localparam int DC_OFF_W       = $clog2(DC_BLOCK_BYTES);
   localparam int DC_IDX_W       = $clog2(DC_LINES);
   localparam int DC_TAG_W       = DC_N - DC_OFF_W - DC_IDX_W;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITEBACK = 2'd1,
      ALLOCATE  = 2'd2
   } state_t;

   // Sized from the package defaults; override geometry here, not per instance.
   typedef struct packed {
      logic                valid;
      logic                dirty;
      logic [DC_TAG_W-1:0] tag;
   } line_meta_t;

endpackage

// File: rtl/dcache_line_store.sv
// Tag/valid/dirty/data arrays: combinational read of one line, one byte write and one metadata write per cycle.
// Zero-latency read, writes land on the rising edge; valid/dirty clear asynchronously, data and tags are not reset.
module dcache_line_store
   import dcache_pkg::*;
#(
   parameter int N           = DC_N,
   parameter int LINES       = DC_LINES,
   parameter int BLOCK_BYTES = DC_BLOCK_BYTES
)(
   input  logic                          clk,
   input  logic                          reset,
   input  logic [$clog2(LINES)-1:0]      index,
   output line_meta_t                    rd_meta,
   output logic [BLOCK_BYTES*N-1:0]      rd_line,
   input  logic                          byte_we,
   input  logic [$clog2(BLOCK_BYTES)-1:0] byte_offset,
   input  logic [N-1:0]                  byte_dat,
   input  logic                          meta_we,
   input  line_meta_t                    meta_dat
);

   logic [LINES-1:0]         valid;
   logic [LINES-1:0]         dirty;
   logic [DC_TAG_W-1:0]      tags [LINES];
   logic [BLOCK_BYTES*N-1:0] data [LINES];

   assign rd_meta = {valid[index], dirty[index], tags[index]};
   assign rd_line = data[index];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid <= '0;
         dirty <= '0;
      end else if (meta_we) begin
         valid[index] <= meta_dat.valid;
         dirty[index] <= meta_dat.dirty;
      end
   end

   always_ff @(posedge clk) begin
      if (meta_we)
         tags[index] <= meta_dat.tag;
      if (byte_we)
         data[index][byte_offset*N +: N] <= byte_dat;
   end

endmodule

// File: rtl/dcache_wb.sv
// Direct-mapped write-back/write-allocate byte cache; hits are zero-stall, misses refill byte by byte.
// busywait stalls the CPU on a miss; each memory beat waits out mem_busywait. DCACHE_STATS_EN adds hit/miss counters.
module dcache_wb
   import dcache_pkg::*;
#(
   parameter int N           = DC_N,
   parameter int LINES       = DC_LINES,
   parameter int BLOCK_BYTES = DC_BLOCK_BYTES
)(
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] address,
   input  logic [N-1:0] writedata,
   input  logic         read,
   input  logic         write,
   output logic [N-1:0] readdata,
   output logic         busywait,
   output logic [N-1:0] mem_address,
   output logic [N-1:0] mem_writedata,
   output logic         mem_read,
   output logic         mem_write,
   input  logic [N-1:0] mem_readdata,
   input  logic         mem_busywait
`ifdef DCACHE_STATS_EN
   ,
   output logic [15:0]  hit_count,
   output logic [15:0]  miss_count
`endif
);

   localparam int OFF_W = $clog2(BLOCK_BYTES);
   localparam int IDX_W = $clog2(LINES);
   localparam int TAG_W = N - OFF_W - IDX_W;

   logic [OFF_W-1:0]         offset;
   logic [IDX_W-1:0]         idx;
   logic [TAG_W-1:0]         tag;
   line_meta_t               rd_meta;
   logic [BLOCK_BYTES*N-1:0] rd_line;
   state_t                   state;
   logic [OFF_W-1:0]         beat;
   logic                     hit, legal, last_beat, alloc_done;
   logic                     byte_we, meta_we;
   logic [OFF_W-1:0]         byte_off;
   logic [N-1:0]             byte_dat;
   line_meta_t               meta_dat;

   assign offset     = address[OFF_W-1:0];
   assign idx        = address[OFF_W +: IDX_W];
   assign tag        = address[N-1 -: TAG_W];
   assign hit        = rd_meta.valid && (rd_meta.tag == tag);
   assign legal      = read ^ write;
   assign last_beat  = (beat == OFF_W'(BLOCK_BYTES - 1));
   assign alloc_done = (state == ALLOCATE) && mem_read && !mem_busywait && last_beat;

   // Gated by reset so the stall drops the instant reset is pulled, even mid-refill.
   assign busywait = reset && ((state != IDLE) || (legal && !hit));
   assign readdata = (reset && state == IDLE && read && !write && hit) ?
                     rd_line[offset*N +: N] : '0;

   dcache_line_store #(
      .N           (N),
      .LINES       (LINES),
      .BLOCK_BYTES (BLOCK_BYTES)
   ) u_store (
      .clk         (clk),
      .reset       (reset),
      .index       (idx),
      .rd_meta     (rd_meta),
      .rd_line     (rd_line),
      .byte_we     (byte_we),
      .byte_offset (byte_off),
      .byte_dat    (byte_dat),
      .meta_we     (meta_we),
      .meta_dat    (meta_dat)
   );

   always_comb begin
      byte_we  = 1'b0;
      meta_we  = 1'b0;
      byte_off = offset;
      byte_dat = writedata;
      meta_dat = '{valid: 1'b1, dirty: 1'b1, tag: tag};
      case (state)
         IDLE: begin
            if (write && !read && hit) begin
               byte_we = 1'b1;
               meta_we = 1'b1;
            end
         end
         ALLOCATE: begin
            if (mem_read && !mem_busywait) begin
               byte_we  = 1'b1;
               byte_off = beat;
               byte_dat = mem_readdata;
               if (last_beat) begin
                  meta_we        = 1'b1;
                  meta_dat.dirty = 1'b0;
               end
            end
         end
         default: ;
      endcase
   end

   // A registered request is always one cycle old at the next edge; dropping it after
   // every completed beat gives the memory a fresh access each time.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         beat          <= '0;
         mem_read      <= 1'b0;
         mem_write     <= 1'b0;
         mem_address   <= '0;
         mem_writedata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (legal && !hit) begin
                  beat <= '0;
                  if (rd_meta.valid && rd_meta.dirty) begin
                     state         <= WRITEBACK;
                     mem_write     <= 1'b1;
                     mem_address   <= {rd_meta.tag, idx, {OFF_W{1'b0}}};
                     mem_writedata <= rd_line[N-1:0];
                  end else begin
                     state       <= ALLOCATE;
                     mem_read    <= 1'b1;
                     mem_address <= {tag, idx, {OFF_W{1'b0}}};
                  end
               end
            end
            WRITEBACK: begin
               if (!mem_write) begin
                  mem_write     <= 1'b1;
                  mem_address   <= {rd_meta.tag, idx, beat};
                  mem_writedata <= rd_line[beat*N +: N];
               end else if (!mem_busywait) begin
                  mem_write <= 1'b0;
                  if (last_beat) begin
                     beat  <= '0;
                     state <= ALLOCATE;
                  end else begin
                     beat <= beat + OFF_W'(1);
                  end
               end
            end
            ALLOCATE: begin
               if (!mem_read) begin
                  mem_read    <= 1'b1;
                  mem_address <= {tag, idx, beat};
               end else if (!mem_busywait) begin
                  mem_read <= 1'b0;
                  if (last_beat) begin
                     beat  <= '0;
                     state <= IDLE;
                  end else begin
                     beat <= beat + OFF_W'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef DCACHE_STATS_EN
   logic post_alloc;

   // The first IDLE cycle after a refill serves the missed request; it is not a new hit.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         post_alloc <= 1'b0;
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         post_alloc <= alloc_done;
         if (state == IDLE && legal && hit && !post_alloc && hit_count != 16'hFFFF)
            hit_count <= hit_count + 16'd1;
         if (state == IDLE && legal && !hit && miss_count != 16'hFFFF)
            miss_count <= miss_count + 16'd1;
      end
   end
`else
   logic unused_alloc_done;
   assign unused_alloc_done = alloc_done;
`endif

endmodule

// File: tb/tb_dcache_wb.sv
// Randomised bench for dcache_wb: a flat "CPU-visible memory" plus a tag/valid/dirty table predict
// every hit/miss, load value and memory beat sequence; a byte memory with random stalls serves the cache.
module tb_dcache_wb;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] address = '0, writedata = '0;
   logic       read = 1'b0, write = 1'b0;
   logic [7:0] readdata;
   logic       busywait;
   logic [7:0] mem_address, mem_writedata, mem_readdata;
   logic       mem_read, mem_write;
   logic       mem_busywait = 1'b0;
`ifdef DCACHE_STATS_EN
   logic [15:0] hit_count, miss_count;
`endif

   dcache_wb dut (
      .clk           (clk),
      .reset         (reset),
      .address       (address),
      .writedata     (writedata),
      .read          (read),
      .write         (write),
      .readdata      (readdata),
      .busywait      (busywait),
      .mem_address   (mem_address),
      .mem_writedata (mem_writedata),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .mem_readdata  (mem_readdata),
      .mem_busywait  (mem_busywait)
`ifdef DCACHE_STATS_EN
      ,
      .hit_count     (hit_count),
      .miss_count    (miss_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         wr;
      logic [7:0] a;
      logic [7:0] d;
   } beat_t;

   logic [7:0] mem    [256];
   logic [7:0] golden [256];
   bit         mvalid [8];
   bit         mdirty [8];
   logic [2:0] mtag   [8];
   beat_t      log_q  [$];
   int         n_checks = 0, n_fail = 0;
   int         exp_hits = 0, exp_misses = 0;
   bit         prev_done = 1'b0;

   assign mem_readdata = mem[mem_address];

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 8; i++) begin
         mvalid[i] = 1'b0;
         mdirty[i] = 1'b0;
         mtag[i]   = '0;
      end
      for (int i = 0; i < 256; i++) golden[i] = mem[i];
      exp_hits   = 0;
      exp_misses = 0;
   endtask

   // Byte memory: stalls at random, a beat completes on the edge after a stall-free sample.
   initial begin
      bit done;
      forever begin
         @(negedge clk);
         if (mem_read || mem_write)
            check("mem_excl", 32'(mem_read & mem_write), 32'd0);
         if (prev_done)
            check("mem_gap", 32'({mem_read, mem_write}), 32'd0);
         mem_busywait = ($urandom_range(0, 3) == 0);
         done = reset && (mem_read || mem_write) && !mem_busywait;
         if (done) begin
            log_q.push_back('{mem_write, mem_address, mem_writedata});
            if (mem_write) mem[mem_address] = mem_writedata;
         end
         prev_done = done;
      end
   end

   task automatic cpu_op(input bit rd, input logic [7:0] a, input logic [7:0] d);
      logic [2:0] idx, tg;
      logic [7:0] ea;
      bit         hit_e;
      beat_t      exp_q [$];
      int         start, cyc;
      idx   = a[4:2];
      tg    = a[7:5];
      hit_e = mvalid[idx] && (mtag[idx] == tg);
      if (!hit_e) begin
         if (mvalid[idx] && mdirty[idx])
            for (int k = 0; k < 4; k++) begin
               ea = {mtag[idx], idx, 2'(k)};
               exp_q.push_back('{1'b1, ea, golden[ea]});
            end
         for (int k = 0; k < 4; k++) begin
            ea = {tg, idx, 2'(k)};
            exp_q.push_back('{1'b0, ea, 8'h00});
         end
      end
      @(negedge clk);
      read = rd; write = !rd; address = a; writedata = d;
      start = log_q.size();
      #1;
      check("busy_first", 32'(busywait), 32'(!hit_e));
      cyc = 0;
      while (busywait && cyc < 300) begin
         @(negedge clk); #1;
         cyc++;
      end
      check("busy_drop", 32'(busywait), 32'd0);
      if (rd) check("readdata", 32'(readdata), 32'(golden[a]));
      else    golden[a] = d;
      check("beat_cnt", 32'(log_q.size() - start), 32'(exp_q.size()));
      foreach (exp_q[i]) begin
         if (start + i < log_q.size()) begin
            check("beat_kind", 32'(log_q[start+i].wr), 32'(exp_q[i].wr));
            check("beat_addr", 32'(log_q[start+i].a), 32'(exp_q[i].a));
            if (exp_q[i].wr) check("beat_data", 32'(log_q[start+i].d), 32'(exp_q[i].d));
         end
      end
      if (hit_e) exp_hits++;
      else begin
         exp_misses++;
         mvalid[idx] = 1'b1;
         mtag[idx]   = tg;
         mdirty[idx] = 1'b0;
      end
      if (!rd) mdirty[idx] = 1'b1;
   endtask

   initial begin
      int start, cyc;
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      mem[8'h24] = 8'h11; mem[8'h25] = 8'h22; mem[8'h26] = 8'h33; mem[8'h27] = 8'h44;
      model_clear();

      #2 reset = 1'b0;
      @(negedge clk); #1;
      check("rst_busy", 32'(busywait), 32'd0);
      check("rst_rdata", 32'(readdata), 32'd0);
      check("rst_mrd", 32'(mem_read), 32'd0);
      check("rst_mwr", 32'(mem_write), 32'd0);
      check("rst_maddr", 32'(mem_address), 32'd0);
      check("rst_mwdata", 32'(mem_writedata), 32'd0);
      @(negedge clk);
      reset = 1'b1;

      cpu_op(1'b1, 8'h25, 8'h00);           // clean miss, refill 0x24..0x27
      cpu_op(1'b1, 8'h26, 8'h00);           // hit
      cpu_op(1'b0, 8'h25, 8'h5A);           // write hit, line dirty
      cpu_op(1'b1, 8'h45, 8'h00);           // dirty miss: writeback then refill
      cpu_op(1'b1, 8'h25, 8'h00);           // refill must see 0x5A

      // Illegal read+write: no stall, no memory traffic, cached state untouched.
      @(negedge clk);
      read = 1'b1; write = 1'b1; address = 8'h10;
      start = log_q.size();
      repeat (4) begin
         #1 check("illegal_busy", 32'(busywait), 32'd0);
         @(negedge clk);
      end
      read = 1'b0; write = 1'b0;
      check("illegal_mem", 32'(log_q.size() - start), 32'd0);
      cpu_op(1'b1, 8'h26, 8'h00);

      // Reset during the second refill beat.
      @(negedge clk);
      read = 1'b1; write = 1'b0; address = 8'h65;
      start = log_q.size();
      cyc = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
      end while (!(mem_read === 1'b1 && log_q.size() == start + 1) && cyc < 300);
      check("rst_reach", 32'(cyc < 300), 32'd1);
      reset = 1'b0;
      #1;
      check("midrst_mrd", 32'(mem_read), 32'd0);
      check("midrst_busy", 32'(busywait), 32'd0);
      check("midrst_mwr", 32'(mem_write), 32'd0);
      read = 1'b0;
      model_clear();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      cpu_op(1'b1, 8'h65, 8'h00);

      for (int n = 0; n < 80; n++)
         cpu_op(1'($urandom_range(0, 1)),
                {3'($urandom_range(0, 2)), 5'($urandom)}, 8'($urandom));

      @(negedge clk);
      read = 1'b0; write = 1'b0;
      #1;
`ifdef DCACHE_STATS_EN
      check("hit_count", 32'(hit_count), 32'(exp_hits));
      check("miss_count", 32'(miss_count), 32'(exp_misses));
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d checks, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog expired");
   end

endmodule
